// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults for the register-file write-port arbiter: widths, queue depth,
// starvation limit, the register-0 index and the per-cycle source selector.
`ifndef RF_WB_ARBITER_PKG_SV
`define RF_WB_ARBITER_PKG_SV
package rf_wb_arbiter_pkg;
  localparam int DATA_W_DEF       = 32;
  localparam int ADDR_W_DEF       = 5;
  localparam int DEPTH_DEF        = 4;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int REG_ZERO         = 0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PRI  = 2'd1,
    SRC_SEC  = 2'd2
  } src_e;
endpackage
`endif

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO for secondary writebacks; exposes per-entry valid/rd taps so
// the arbiter can report pending writes without draining the queue.
module rf_wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_rd,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [ADDR_W-1:0]             head_rd,
  output logic [DATA_W-1:0]             head_data,
  output logic [CNT_W-1:0]              count,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_rd
);
  logic [DEPTH-1:0][ADDR_W-1:0] rd_mem;
  logic [DATA_W-1:0]            data_mem [DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic                         do_push;
  logic                         do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign ent_rd    = rd_mem;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr            <= wr_ptr + PTR_W'(1);
        ent_valid[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr            <= rd_ptr + PTR_W'(1);
        ent_valid[rd_ptr] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: primary WB wins unless the secondary queue
// starves; optional same-cycle forwarding is enabled with `define RF_WB_FWD_EN.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [ADDR_W-1:0] sec_rd,
  input  logic [DATA_W-1:0] sec_data,
  output logic              stall_req,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  output logic              pend_rs,
  output logic              pend_rt,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  logic                         q_push;
  logic                         q_pop;
  logic [ADDR_W-1:0]            q_head_rd;
  logic [DATA_W-1:0]            q_head_data;
  logic [CNT_W-1:0]             q_count;
  logic                         q_full;
  logic                         q_empty;
  logic [DEPTH-1:0]             q_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] q_rd;

  logic                         pri_ok;
  src_e                         sel;
  logic [SC_W-1:0]              starve_cnt;
  logic [SC_W-1:0]              starve_next;

  // Handshake: a secondary write transfers on a cycle where sec_valid & sec_ready;
  // sec_ready reflects only registered queue occupancy. rd==0 transfers are dropped.
  assign sec_ready = ~q_full;
  assign q_push    = sec_valid & sec_ready & (sec_rd != RZ);
  assign pri_ok    = wb_valid & (wb_rd != RZ);
  assign q_pop     = (sel == SRC_SEC);

  rf_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_rd   (sec_rd),
    .push_data (sec_data),
    .pop       (q_pop),
    .head_rd   (q_head_rd),
    .head_data (q_head_data),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty),
    .ent_valid (q_valid),
    .ent_rd    (q_rd)
  );

  // A raised stall_req hands the port to the queue even if the pipeline ignores it.
  always_comb begin
    sel = SRC_NONE;
    if (!q_empty && (stall_req || !pri_ok)) sel = SRC_SEC;
    else if (pri_ok)                         sel = SRC_PRI;
  end

  always_comb begin
    starve_next = starve_cnt;
    if (q_pop || q_count == '0)
      starve_next = '0;
    else if (sel == SRC_PRI && starve_cnt != SC_W'(STARVE_LIMIT))
      starve_next = starve_cnt + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write   <= 1'b0;
      rf_rd      <= '0;
      rf_data    <= '0;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      rf_write   <= (sel != SRC_NONE);
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == SC_W'(STARVE_LIMIT));
      case (sel)
        SRC_PRI: begin
          rf_rd   <= wb_rd;
          rf_data <= wb_data;
        end
        SRC_SEC: begin
          rf_rd   <= q_head_rd;
          rf_data <= q_head_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pend_rs = rf_write & (rf_rd == q_rs);
    pend_rt = rf_write & (rf_rd == q_rt);
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && q_rd[i] == q_rs) pend_rs = 1'b1;
      if (q_valid[i] && q_rd[i] == q_rt) pend_rt = 1'b1;
    end
    if (q_rs == RZ) pend_rs = 1'b0;
    if (q_rt == RZ) pend_rt = 1'b0;
  end

`ifdef RF_WB_FWD_EN
  assign fwd_hit  = rf_write & (rf_rd == q_rs) & (q_rs != RZ);
  assign fwd_data = rf_data;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 8;

  logic              clk;
  logic              reset;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              sec_valid;
  logic              sec_ready;
  logic [ADDR_W-1:0] sec_rd;
  logic [DATA_W-1:0] sec_data;
  logic              stall_req;
  logic [ADDR_W-1:0] q_rs;
  logic [ADDR_W-1:0] q_rt;
  logic              pend_rs;
  logic              pend_rt;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  rf_wb_arbiter #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk), .reset (reset),
    .wb_valid (wb_valid), .wb_rd (wb_rd), .wb_data (wb_data),
    .sec_valid (sec_valid), .sec_ready (sec_ready), .sec_rd (sec_rd), .sec_data (sec_data),
    .stall_req (stall_req), .q_rs (q_rs), .q_rt (q_rt),
    .pend_rs (pend_rs), .pend_rt (pend_rt),
    .rf_write (rf_write), .rf_rd (rf_rd), .rf_data (rf_data),
    .fwd_hit (fwd_hit), .fwd_data (fwd_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              m_q[$];
  int                m_starve;
  bit                m_stall;
  bit                m_write;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_rf  [32];
  logic [DATA_W-1:0] obs_rf[32];

  logic [ADDR_W+DATA_W:0] exp_q[$];

  int n_cmp;
  int n_bad;

  initial begin
    m_starve = 0;
    m_stall  = 1'b0;
    m_write  = 1'b0;
    m_rd     = '0;
    m_data   = '0;
    n_cmp    = 0;
    n_bad    = 0;
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = '0;
      obs_rf[i] = '0;
    end
  end

  // The register file sees one write per cycle: the queue head if the queue is
  // starving (or primary is absent), otherwise a valid non-zero primary write.
  always @(posedge clk) begin : model
    bit   nonempty;
    bit   ready;
    bit   pri_ok;
    ent_t e;
    if (reset) begin
      m_q.delete();
      m_starve = 0;
      m_stall  = 1'b0;
      m_write  = 1'b0;
      m_rd     = '0;
      m_data   = '0;
    end else begin
      nonempty = (m_q.size() > 0);
      ready    = (m_q.size() < DEPTH);
      pri_ok   = wb_valid && (wb_rd != 0);
      if (nonempty && (m_stall || !pri_ok)) begin
        e        = m_q.pop_front();
        m_write  = 1'b1;
        m_rd     = e.rd;
        m_data   = e.data;
        m_starve = 0;
      end else if (pri_ok) begin
        m_write  = 1'b1;
        m_rd     = wb_rd;
        m_data   = wb_data;
        m_starve = nonempty ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else begin
        m_write  = 1'b0;
        m_starve = 0;
      end
      if (m_write) m_rf[m_rd] = m_data;
      if (sec_valid && ready && sec_rd != 0) begin
        e.rd   = sec_rd;
        e.data = sec_data;
        m_q.push_back(e);
      end
      m_stall = (m_starve >= LIMIT);
    end
    exp_q.push_back({m_write, m_rd, m_data});
  end

  function automatic bit model_pend(input logic [ADDR_W-1:0] q);
    if (q == 0) return 1'b0;
    if (m_write && m_rd == q) return 1'b1;
    foreach (m_q[i]) if (m_q[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [ADDR_W+DATA_W:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("rf_write", 64'(rf_write), 64'(exp[ADDR_W+DATA_W]));
      check("rf_rd",    64'(rf_rd),    64'(exp[ADDR_W+DATA_W-1:DATA_W]));
      check("rf_data",  64'(rf_data),  64'(exp[DATA_W-1:0]));
      check("sec_ready", 64'(sec_ready), 64'(m_q.size() < DEPTH));
      check("stall_req", 64'(stall_req), 64'(m_stall));
      check("pend_rs",   64'(pend_rs),   64'(model_pend(q_rs)));
      check("pend_rt",   64'(pend_rt),   64'(model_pend(q_rt)));
`ifdef RF_WB_FWD_EN
      check("fwd_hit",  64'(fwd_hit),  64'(m_write && m_rd == q_rs && q_rs != 0));
      check("fwd_data", 64'(fwd_data), 64'(m_data));
`else
      check("fwd_hit",  64'(fwd_hit),  64'(0));
      check("fwd_data", 64'(fwd_data), 64'(0));
`endif
    end
    if (rf_write) obs_rf[rf_rd] = rf_data;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rst, input bit wv, input logic [ADDR_W-1:0] wr,
                       input logic [DATA_W-1:0] wd, input bit sv,
                       input logic [ADDR_W-1:0] sr, input logic [DATA_W-1:0] sd,
                       input logic [ADDR_W-1:0] qs, input logic [ADDR_W-1:0] qt);
    @(negedge clk);
    #2;
    reset     = rst;
    wb_valid  = wv;
    wb_rd     = wr;
    wb_data   = wd;
    sec_valid = sv;
    sec_rd    = sr;
    sec_data  = sd;
    q_rs      = qs;
    q_rt      = qt;
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] qs);
    repeat (n) drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, qs, qs);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    sec_valid = 1'b0; sec_rd = '0; sec_data = '0; q_rs = '0; q_rt = '0;
    repeat (2) drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);

    // idle after reset, sweeping the pending queries
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ADDR_W'(i * 4), ADDR_W'(i));

    // single primary write
    drive(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, '0, '0, 5'd3, 5'd3);
    idle(2, 5'd3);

    // two secondary writes to the same register, primary idle
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd7);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    idle(4, 5'd7);

    // fill the queue while the primary holds the port, until starvation stalls it
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b1, ADDR_W'($urandom_range(1, 31)), $urandom, 1'b1,
            ADDR_W'(8 + i), 32'h100 + 32'(i), ADDR_W'(8 + i), 5'd9);
    for (int i = 0; i < 20; i++) begin
      if (stall_req) break;
      drive(1'b0, 1'b1, ADDR_W'($urandom_range(1, 31)), $urandom, 1'b0, '0, '0, 5'd8, 5'd11);
    end
    idle(8, 5'd10);

    // primary to r0 lets the queue pop; sec_rd=0 handshake is dropped
    drive(1'b0, 1'b1, 5'd9, $urandom, 1'b1, 5'd5, 32'h55, 5'd5, 5'd9);
    drive(1'b0, 1'b1, 5'd0, $urandom, 1'b1, 5'd0, 32'h99, 5'd5, 5'd0);
    idle(3, 5'd5);

    // reset with three entries queued
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 5'd10, $urandom, 1'b1, ADDR_W'(11 + i), $urandom, 5'd11, 5'd12);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd11, 5'd13);
    for (int i = 0; i < 5; i++) idle(1, ADDR_W'(11 + (i % 3)));

    // randomized traffic; the pipeline mostly honours stall_req
    for (int i = 0; i < 3000; i++) begin
      bit wv;
      wv = ($urandom_range(0, 3) != 0) && (!stall_req || $urandom_range(0, 9) == 0);
      drive($urandom_range(0, 299) == 0, wv, ADDR_W'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom,
            ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15)));
    end
    idle(12, '0);

    @(negedge clk);
    #3;
    for (int r = 0; r < 32; r++)
      check($sformatf("regfile_r%0d", r), 64'(obs_rf[r]), 64'(m_rf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-side front end for the 32x32 register file's single write port.
- Merges two writeback sources into one registered write stream (rf_write/rf_rd/rf_data):
  - primary in-order pipeline WB stage, which cannot be back-pressured;
  - secondary multi-cycle unit (mul/div), which uses a valid/ready handshake and is buffered in a small queue.
- Also exports pending-write status so decode can stall on registers not yet written.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- DEPTH, 4, secondary queue entries (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive primary-won cycles with a non-empty queue before stall_req asserts.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  primary write present this cycle.
- wb_rd  in  ADDR_W  primary destination.
- wb_data  in  DATA_W  primary data.
- sec_valid  in  1  secondary write offered.
- sec_ready  out  1  secondary write accepted when sec_valid & sec_ready.
- sec_rd  in  ADDR_W  secondary destination.
- sec_data  in  DATA_W  secondary data.
- stall_req  out  1  pipeline must hold wb_valid low next cycle.
- q_rs  in  ADDR_W  pending query A.
- q_rt  in  ADDR_W  pending query B.
- pend_rs  out  1  q_rs has a write queued or in the output stage.
- pend_rt  out  1  same for q_rt.
- rf_write  out  1  write enable to register file.
- rf_rd  out  ADDR_W  write index.
- rf_data  out  DATA_W  write data.
- fwd_hit  out  1  (RF_WB_FWD_EN) output stage matches q_rs.
- fwd_data  out  DATA_W  (RF_WB_FWD_EN) forwarded value.

Behaviour:
- Reset (synchronous, active-high): queue empty, starve counter 0, rf_write=0, rf_rd=0, rf_data=0, stall_req=0.
  - Reset mid-operation discards all queued entries without writing them.
- Output stage is registered. Latency is 1 cycle from selected input to rf_write; the register file commits at the end of that cycle.
- Per-cycle select, in priority order:
  1. wb_valid=1 and wb_rd!=0: output stage loads primary.
  2. Queue non-empty: pop head into output stage.
  3. Otherwise rf_write=0 next cycle; rf_rd/rf_data hold their last values.
- Register 0:
  - Primary writes with wb_rd=0 are ignored and do not claim the port; the queue may pop that cycle.
  - Secondary handshakes with sec_rd=0 complete (sec_ready honoured) but are not enqueued.
- Queue:
  - FIFO order, DEPTH entries.
  - sec_ready = (count<DEPTH), registered-state only; it does not depend on pop in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Wrap-around via ADDR pointers modulo DEPTH.
- Starve counter:
  - Increments when the queue is non-empty and primary wins.
  - Clears on any pop or when the queue is empty.
  - stall_req is asserted registered when the counter reaches STARVE_LIMIT.
  - While stall_req=1 the queue head wins even if wb_valid=1 (protocol violation; the primary write is lost). stall_req deasserts the cycle after the pop.
- Pending:
  - pend_x = 1 if any valid queue entry has rd==q_x, or rf_write=1 with rf_rd==q_x.
  - q_x=0 always reports 0. Combinational from state.
- Duplicate rd in the queue is legal; FIFO order guarantees the last write wins.

Optional Feature:
- RF_WB_FWD_EN defined:
  - fwd_hit = rf_write & (rf_rd==q_rs) & (q_rs!=0).
  - fwd_data = rf_data.
  - Lets decode bypass the same-cycle write.
- Undefined: fwd_hit=0, fwd_data=0, no comparator logic.

Decomposition:
- Shared header with include guard, holding:
  - default widths;
  - DEPTH;
  - STARVE_LIMIT;
  - the register-0 index constant.
- One sub-module, rf_wb_fifo: parameterised DEPTH x (ADDR_W+DATA_W) sync FIFO with count, full/empty, and per-entry valid/rd taps for the pending compare.

Test Plan:
- Reset then idle: rf_write=0, sec_ready=1, pend_rs=0 for all q_rs.
- Primary wb_rd=3, data 0xA5A5A5A5: next cycle rf_write=1, rf_rd=3, rf_data=0xA5A5A5A5; pend for 3 =1 that cycle only.
- Push secondary rd=7/0x11 and rd=7/0x22 with primary idle: two writes in order; final register 7 = 0x22.
- Fill 4 entries with wb_valid held 1: sec_ready=0 on the 5th offer.
  - stall_req asserts after 8 primary-won cycles.
  - Pipeline drops wb_valid and the queue drains in order.
- wb_rd=0 with queue holding rd=5: rd=5 pops that cycle; sec_rd=0 handshake accepted, count unchanged.
- Reset asserted with 3 entries queued: next cycle count=0, rf_write=0, pend=0, and no stale writes follow.
